// File: rtl/if_id_reg_pkg.sv
// rtl/if_id_reg_pkg.sv - shared pipeline-register widths, NOP encoding and bubble values
package if_id_reg_pkg;

    localparam int NB_PC          = 32;
    localparam int NB_INSTRUCTION = 32;

    // MIPS sll r0,r0,0: architecturally a no-op, so a bubble can flow through decode safely
    localparam logic [NB_INSTRUCTION-1:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [NB_PC-1:0] PC_BUBBLE    = '0;
    localparam logic             VALID_BUBBLE = 1'b0;

    typedef struct packed {
        logic [NB_PC-1:0]          adder_result;
        logic [NB_INSTRUCTION-1:0] instruction;
        logic                      valid;
    } if_id_slot_t;

    function automatic if_id_slot_t bubble_slot();
        if_id_slot_t s;
        s.adder_result = PC_BUBBLE;
        s.instruction  = NOP_INSTR;
        s.valid        = VALID_BUBBLE;
        return s;
    endfunction

endpackage

// File: rtl/if_id_reg_if.sv
// rtl/if_id_reg_if.sv - IF-to-ID pipeline register bus with master/slave views
interface if_id_reg_if
    import if_id_reg_pkg::*;
#(
    parameter int NB_PC_W          = if_id_reg_pkg::NB_PC,
    parameter int NB_INSTRUCTION_W = if_id_reg_pkg::NB_INSTRUCTION
);

    logic                        i_enable;
    logic                        i_flush;
    logic [NB_PC_W-1:0]          i_IF_adder_result;
    logic [NB_INSTRUCTION_W-1:0] i_IF_instruction;
    logic [NB_PC_W-1:0]          o_ID_adder_result;
    logic [NB_INSTRUCTION_W-1:0] o_ID_instruction;
    logic                        o_ID_valid;

    // master is the IF stage / hazard unit side that drives the register
    modport master (
        output i_enable,
        output i_flush,
        output i_IF_adder_result,
        output i_IF_instruction,
        input  o_ID_adder_result,
        input  o_ID_instruction,
        input  o_ID_valid
    );

    modport slave (
        input  i_enable,
        input  i_flush,
        input  i_IF_adder_result,
        input  i_IF_instruction,
        output o_ID_adder_result,
        output o_ID_instruction,
        output o_ID_valid
    );

endinterface

// File: rtl/if_id_reg_pipe_field_reg.sv
// rtl/if_id_reg_pipe_field_reg.sv - one pipeline field: sync reset, flush value, enable hold
module pipe_field_reg #(
    parameter int           W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0,
    parameter logic [W-1:0] FLUSH_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Flush is checked before enable so a stalled slot that must be squashed never keeps stale data
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (flush) begin
            q <= FLUSH_VAL;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with stall, flush and valid flag
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter int                        NB_PC          = if_id_reg_pkg::NB_PC,
    parameter int                        NB_INSTRUCTION = if_id_reg_pkg::NB_INSTRUCTION,
    parameter logic [NB_INSTRUCTION-1:0] NOP_INSTR      = if_id_reg_pkg::NOP_INSTR
) (
    input logic        i_clock,
    input logic        i_reset,
    if_id_reg_if.slave bus
);

    pipe_field_reg #(
        .W         (NB_PC),
        .RESET_VAL ('0),
        .FLUSH_VAL ('0)
    ) u_adder_result (
        .clock  (i_clock),
        .reset  (i_reset),
        .enable (bus.i_enable),
        .flush  (bus.i_flush),
        .d      (bus.i_IF_adder_result),
        .q      (bus.o_ID_adder_result)
    );

    pipe_field_reg #(
        .W         (NB_INSTRUCTION),
        .RESET_VAL (NOP_INSTR),
        .FLUSH_VAL (NOP_INSTR)
    ) u_instruction (
        .clock  (i_clock),
        .reset  (i_reset),
        .enable (bus.i_enable),
        .flush  (bus.i_flush),
        .d      (bus.i_IF_instruction),
        .q      (bus.o_ID_instruction)
    );

    // Every enabled load is a real fetch, so the valid field just loads a constant one
    pipe_field_reg #(
        .W         (1),
        .RESET_VAL (VALID_BUBBLE),
        .FLUSH_VAL (VALID_BUBBLE)
    ) u_valid (
        .clock  (i_clock),
        .reset  (i_reset),
        .enable (bus.i_enable),
        .flush  (bus.i_flush),
        .d      (1'b1),
        .q      (bus.o_ID_valid)
    );

endmodule

// File: tb/tb_if_id_reg.sv
// tb/tb_if_id_reg.sv - self-checking bench for if_id_reg against a slot-level reference model
module tb_if_id_reg;
    import if_id_reg_pkg::*;

    logic i_clock;
    logic i_reset;

    if_id_reg_if bus ();

    if_id_reg dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int vectors     = 0;
    int miscompares = 0;

    if_id_slot_t exp_slot;
    logic [31:0] pc_seen1 = '0, pc_seen0 = '0, in_seen1 = '0, in_seen0 = '0;

    task automatic check(input string tag);
        vectors++;
        assert (bus.o_ID_adder_result === exp_slot.adder_result) else begin
            miscompares++;
            $error("FAIL %s adder_result got %h expected %h", tag, bus.o_ID_adder_result, exp_slot.adder_result);
        end
        assert (bus.o_ID_instruction === exp_slot.instruction) else begin
            miscompares++;
            $error("FAIL %s instruction got %h expected %h", tag, bus.o_ID_instruction, exp_slot.instruction);
        end
        assert (bus.o_ID_valid === exp_slot.valid) else begin
            miscompares++;
            $error("FAIL %s valid got %b expected %b", tag, bus.o_ID_valid, exp_slot.valid);
        end
        pc_seen1 |= bus.o_ID_adder_result;
        pc_seen0 |= ~bus.o_ID_adder_result;
        in_seen1 |= bus.o_ID_instruction;
        in_seen0 |= ~bus.o_ID_instruction;
    endtask

    // Apply one edge of stimulus, advance the model by the slot rules, then sample after the edge
    task automatic step(input logic rst, input logic en, input logic fl,
                        input logic [31:0] pc, input logic [31:0] ins, input string tag);
        i_reset               = rst;
        bus.i_enable          = en;
        bus.i_flush           = fl;
        bus.i_IF_adder_result = pc;
        bus.i_IF_instruction  = ins;
        @(posedge i_clock);
        if (rst === 1'b1 || fl === 1'b1) begin
            exp_slot = bubble_slot();
        end else if (en === 1'b1) begin
            exp_slot.adder_result = pc;
            exp_slot.instruction  = ins;
            exp_slot.valid        = 1'b1;
        end
        #1;
        check(tag);
    endtask

    initial begin
        logic r, e, f;
        exp_slot = bubble_slot();
        @(negedge i_clock);

        step(1, 1, 0, 32'h0000_0004, 32'h2008_0005, "reset_0");
        step(1, 1, 0, 32'h0000_0004, 32'h2008_0005, "reset_1");
        step(0, 1, 0, 32'h0000_0004, 32'h2008_0005, "first_load");

        step(1, 1, 0, 32'h0000_0004, 32'h2008_0005, "reset_again");
        step(0, 0, 0, 32'h0000_0004, 32'h2008_0005, "post_reset_no_enable");

        step(0, 1, 0, 32'h0000_0004, 32'h2008_0005, "stream_4");
        step(0, 1, 0, 32'h0000_0008, 32'h2009_0003, "stream_8");
        step(0, 1, 0, 32'h0000_000C, 32'h0109_5020, "stream_12");

        step(0, 1, 0, 32'h0000_0008, 32'h2009_0003, "stall_load");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 32'h0000_000C, 32'h0109_5020, "stall_hold");
        step(0, 1, 0, 32'h0000_000C, 32'h0109_5020, "stall_release");

        step(0, 1, 1, 32'h0000_000C, 32'h0109_5020, "flush");
        step(0, 1, 0, 32'h0000_000C, 32'h0109_5020, "after_flush");

        step(0, 0, 1, 32'h0000_0010, 32'h1234_5678, "flush_beats_stall");
        step(0, 1, 0, 32'h0000_0014, 32'h2008_0005, "reload");
        step(1, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, "reset_beats_load");
        step(1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, "reset_with_flush_stall");

        step(0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, "width_ones");
        step(0, 0, 0, 32'hxxxx_xxxx, 32'hxxxx_xxxx, "x_inputs_held");
        step(0, 1, 0, 32'h0000_0000, 32'h0000_0000, "width_zeros");
        step(0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "width_all_ones");

        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) == 0);
            f = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            step(r, e, f, $urandom, $urandom, "random");
        end

        vectors++;
        assert ((pc_seen1 & pc_seen0) === 32'hFFFF_FFFF) else begin
            miscompares++;
            $error("FAIL toggle_adder_result got %h expected %h", pc_seen1 & pc_seen0, 32'hFFFF_FFFF);
        end
        vectors++;
        assert ((in_seen1 & in_seen0) === 32'hFFFF_FFFF) else begin
            miscompares++;
            $error("FAIL toggle_instruction got %h expected %h", in_seen1 & in_seen0, 32'hFFFF_FFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
